// File: rtl/chroni_pkg.sv
// chroni_pkg: fetch states, RGB565 type, default VGA timing and palette reset ramp.
package chroni_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TXT, S_ATR, S_FNT, S_CAPA, S_CAPF} fetch_state_t;
  typedef logic [15:0] rgb565_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 60;
  function automatic rgb565_t pal_reset(input logic [3:0] i);
    return {i, i[0], i, i[0], i[0], i, i[0]};
  endfunction
endpackage

// File: rtl/chroni_palette.sv
// chroni_palette: 16-entry RGB565 register file, one synchronous write port, one combinational read port.
module chroni_palette
  import chroni_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [3:0] i_widx,
  input  rgb565_t    i_wdata,
  input  logic [3:0] i_ridx,
  output rgb565_t    o_rgb
);
  rgb565_t r_pal [16];
  always_ff @(posedge clk)
    if (!rst_n) for (int k = 0; k < 16; k++) r_pal[k] <= pal_reset(4'(k));
    else if (i_we) r_pal[i_widx] <= i_wdata;
  assign o_rgb = r_pal[i_ridx];
endmodule

// File: rtl/chroni_text_engine.sv
// chroni_text_engine: text-mode VGA generator with shared-port fetch and writable palette.
// Define CHRONI_CURSOR_EN to add the blinking cursor (cursor_col/cursor_row ports).
module chroni_text_engine
  import chroni_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] TEXT_BASE = 16'h0400,
  parameter logic [ADDR_W-1:0] ATTR_BASE = 16'h1400,
  parameter logic [ADDR_W-1:0] FONT_BASE = 16'h0000
) (
  input  logic              vga_clk,
  input  logic              reset_n,
`ifdef CHRONI_CURSOR_EN
  input  logic [7:0]        cursor_col,
  input  logic [7:0]        cursor_row,
`endif
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [4:0]        vga_r,
  output logic [5:0]        vga_g,
  output logic [4:0]        vga_b,
  output logic [ADDR_W-1:0] addr_out,
  output logic              mem_rd,
  input  logic [7:0]        data_in,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [15:0]       pal_data,
  output logic              frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HA = H_SYNC + H_BP;
  localparam int VA = V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SY = HW'(H_SYNC);
  localparam logic [HW-1:0] H_A0 = HW'(HA);
  localparam logic [HW-1:0] H_A1 = HW'(HA + COLS * 8);
  localparam logic [HW-1:0] H_PF = HW'(HA - 8);
  localparam logic [HW-1:0] H_PE = HW'(HA + COLS * 8 - 8);
  localparam logic [HW-1:0] H_ST0 = HW'(HA - 9);
  localparam logic [HW-1:0] H_ST1 = HW'(HA + COLS * 8 - 9);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SY = VW'(V_SYNC);
  localparam logic [VW-1:0] V_A0 = VW'(VA);
  localparam logic [VW-1:0] V_A1 = VW'(VA + ROWS * 8);
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic w_h_last, w_vact, w_de, w_start, w_load;
  logic [2:0] w_slot;
  logic [7:0] w_glyph;
  logic [3:0] w_idx;
  rgb565_t w_rgb;
  fetch_state_t r_state;
  logic [ADDR_W-1:0] r_addr, r_row_base;
  logic r_rd, r_hs, r_vs, r_de, r_fs;
  logic [7:0] r_col, r_attr_nx, r_font_nx, r_attr, r_shift;
  logic [2:0] r_scan;
  rgb565_t r_rgb;
  assign w_h_last = r_h == H_LAST;
  assign w_vact = r_v >= V_A0 && r_v < V_A1;
  assign w_de = w_vact && r_h >= H_A0 && r_h < H_A1;
  assign w_slot = 3'(r_h - H_PF);
  // a cell slot starts every 8 clocks from H_PF; w_start fires the clock before each one
  assign w_start = w_vact && r_h >= H_ST0 && r_h < H_ST1 && w_slot == 3'd7;
  assign w_load = w_vact && r_h >= H_PF && r_h < H_PE && w_slot == 3'd7;
  always_ff @(posedge vga_clk)
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end
  always_ff @(posedge vga_clk)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_rd <= 1'b0;
      r_col <= '0;
      r_attr_nx <= '0;
      r_font_nx <= '0;
      r_attr <= '0;
      r_shift <= '0;
      r_scan <= '0;
      r_row_base <= '0;
    end else begin
      r_rd <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= w_start ? S_TXT : S_IDLE;
        S_TXT: begin
          r_state <= S_ATR;
          r_addr <= TEXT_BASE + r_row_base + ADDR_W'(r_col);
          r_rd <= 1'b1;
        end
        S_ATR: begin
          r_state <= S_FNT;
          r_addr <= ATTR_BASE + r_row_base + ADDR_W'(r_col);
          r_rd <= 1'b1;
          r_col <= r_col + 1'b1;
        end
        S_FNT: begin
          r_state <= S_CAPA;
          r_addr <= FONT_BASE + ADDR_W'({data_in, r_scan});
          r_rd <= 1'b1;
        end
        S_CAPA: begin
          r_state <= S_CAPF;
          r_attr_nx <= data_in;
        end
        S_CAPF: begin
          r_state <= S_IDLE;
          r_font_nx <= w_glyph;
        end
        default: r_state <= S_IDLE;
      endcase
      r_shift <= w_load ? r_font_nx : {r_shift[6:0], 1'b0};
      if (w_load) r_attr <= r_attr_nx;
      if (r_h == '0) r_col <= '0;
      if (w_h_last && w_vact) begin
        r_scan <= r_scan + 1'b1;
        if (r_scan == 3'd7) r_row_base <= r_row_base + ADDR_W'(COLS);
      end
      if (w_h_last && r_v == V_LAST) begin
        r_scan <= '0;
        r_row_base <= '0;
      end
    end
`ifdef CHRONI_CURSOR_EN
  logic [5:0] r_frames;
  logic [7:0] r_row;
  always_ff @(posedge vga_clk)
    if (!reset_n) begin
      r_frames <= '0;
      r_row <= '0;
    end else if (w_h_last && r_v == V_LAST) begin
      r_frames <= r_frames + 1'b1;
      r_row <= '0;
    end else if (w_h_last && w_vact && r_scan == 3'd7) r_row <= r_row + 1'b1;
  // r_col has already advanced past the cell whose glyph arrives in S_CAPF
  assign w_glyph = (r_frames[5] && r_scan[2:1] == 2'b11 && r_row == cursor_row &&
                    r_col - 8'd1 == cursor_col) ? 8'hFF : data_in;
`else
  assign w_glyph = data_in;
`endif
  assign w_idx = r_shift[7] ? r_attr[7:4] : r_attr[3:0];
  chroni_palette u_pal (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .i_we   (pal_we),
    .i_widx (pal_idx),
    .i_wdata(pal_data),
    .i_ridx (w_idx),
    .o_rgb  (w_rgb)
  );
  always_ff @(posedge vga_clk)
    if (!reset_n) begin
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_de <= 1'b0;
      r_rgb <= '0;
      r_fs <= 1'b0;
    end else begin
      r_hs <= r_h >= H_SY;
      r_vs <= r_v >= V_SY;
      r_de <= w_de;
      r_rgb <= w_de ? w_rgb : '0;
      r_fs <= r_h == '0 && r_v == '0;
    end
  assign vga_hs = r_hs;
  assign vga_vs = r_vs;
  assign vga_de = r_de;
  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign addr_out = r_addr;
  assign mem_rd = r_rd;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_chroni_text_engine.sv
// tb_chroni_text_engine: directed checks of a scaled 32x21-clock frame (2x2 text cells).
module tb_chroni_text_engine;
  logic clk = 1'b0;
  logic reset_n;
  logic vga_hs, vga_vs, vga_de, mem_rd, frame_start;
  logic [4:0] vga_r, vga_b;
  logic [5:0] vga_g;
  logic [15:0] addr_out, pal_data;
  logic [7:0] data_in = 8'h00;
  logic pal_we;
  logic [3:0] pal_idx;
  int n_cmp = 0, n_bad = 0;
  int oh, ov, pend, n_hs, n_vs;
  logic [15:0] fg, bg;
  logic [7:0] font = 8'hA5;

  always #5 clk = ~clk;

  chroni_text_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(10),
    .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .COLS(2), .ROWS(2), .ADDR_W(16)
  ) dut (
    .vga_clk    (clk),
    .reset_n    (reset_n),
`ifdef CHRONI_CURSOR_EN
    .cursor_col (8'hFF),
    .cursor_row (8'hFF),
`endif
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_de     (vga_de),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .addr_out   (addr_out),
    .mem_rd     (mem_rd),
    .data_in    (data_in),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
    .frame_start(frame_start)
  );

  function automatic logic [7:0] memv(input logic [15:0] a);
    return (a >= 16'h1400) ? 8'h1E : (a >= 16'h0400) ? 8'h41 : font;
  endfunction

  always @(posedge clk) data_in <= mem_rd ? memv(addr_out) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @(h%0d,v%0d): observed %0h expected %0h", tag, oh, ov, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
    chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
    chk({tag, "_de"}, 32'(vga_de), 32'd0);
    chk({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, "_addr"}, 32'(addr_out), 32'd0);
    chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic cyc;
    logic [15:0] e_rgb, e_addr;
    logic e_de, e_rd;
    int s;
    @(negedge clk);
    if (pend > 0) begin
      pend--;
      if (pend == 0) fg = 16'hF800;
    end
    if (!vga_hs) n_hs++;
    if (!vga_vs) n_vs++;
    e_de = ov >= 4 && ov < 20 && oh >= 14 && oh < 30;
    e_rgb = 16'h0000;
    if (e_de) e_rgb = font[7 - ((oh - 14) % 8)] ? fg : bg;
    s = (oh >= 6) ? (oh - 6) % 8 : 7;
    e_rd = ov >= 4 && ov < 20 && oh >= 6 && oh < 22 && s < 3;
    e_addr = (s == 0) ? 16'(16'h0400 + 2 * ((ov - 4) / 8) + (oh - 6) / 8) :
             (s == 1) ? 16'(16'h1400 + 2 * ((ov - 4) / 8) + (oh - 6) / 8) :
                        16'(16'h0208 + (ov - 4) % 8);
    chk("hs", 32'(vga_hs), 32'(oh >= 4));
    chk("vs", 32'(vga_vs), 32'(ov >= 2));
    chk("de", 32'(vga_de), 32'(e_de));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("frame_start", 32'(frame_start), 32'(oh == 0 && ov == 0));
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    if (e_rd) chk("addr", 32'(addr_out), 32'(e_addr));
    if (oh == 31) begin
      oh = 0;
      ov = (ov == 20) ? 0 : ov + 1;
    end else oh++;
  endtask

  initial begin
    reset_n = 1'b0;
    pal_we = 1'b0;
    pal_idx = 4'd0;
    pal_data = 16'h0000;
    oh = 0;
    ov = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    reset_n = 1'b1;
    fg = 16'h18E3;
    bg = 16'hE71C;
    pend = 0;
    n_hs = 0;
    n_vs = 0;
    for (int i = 0; i < 672; i++) cyc();
    chk("hs_low_per_frame", 32'(n_hs), 32'd84);
    chk("vs_low_per_frame", 32'(n_vs), 32'd64);
    for (int i = 0; i < 672; i++) begin
      cyc();
      if (i == 5 * 32 + 20) begin
        pal_we = 1'b1;
        pal_idx = 4'd1;
        pal_data = 16'hF800;
        pend = 2;
      end
      if (i == 5 * 32 + 21) pal_we = 1'b0;
    end
    for (int i = 0; i < 10 * 32 + 21; i++) cyc();
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    @(negedge clk);
    chk_reset("rst_hold");
    reset_n = 1'b1;
    oh = 0;
    ov = 0;
    fg = 16'h18E3;
    pend = 0;
    for (int i = 0; i < 673; i++) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
